// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register and instruction-fetch sequencer. Holds the
// current PC, fetches the instruction at that PC from instruction memory
// (valid/ready request, valid-only response), presents it to decode and
// loads the next PC when the core signals completion. Misaligned PCs and
// response timeouts park the unit in a sticky fault state until reset.
//
// Parameters
//   TIMEOUT            WAIT cycles without a response before a bus fault (>= 1)
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_reset            synchronous active-high reset
//   i_start_pc         PC loaded while reset is asserted
//   i_next_pc          next PC, taken on an accepted advance
//   i_advance          core done with current instruction (honoured in HOLD)
//   o_imem_req_valid   fetch request valid
//   i_imem_req_ready   memory accepts the request
//   o_imem_addr        fetch address (always the current PC)
//   i_imem_rsp_valid   response data valid
//   i_imem_rsp_data    instruction word
//   o_current_pc       PC of the instruction being fetched or held
//   o_instruction      captured instruction word
//   o_instr_valid      o_instruction is valid for o_current_pc
//   o_misalign_fault   sticky, a PC had bits [1:0] != 0
//   o_bus_fault        sticky, a response timed out
//   o_fetch_count      number of responses captured (wraps)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one cycle after reset, checks alignment of the start PC
// S_REQ   | request asserted, waiting for memory to accept it
// S_WAIT  | request accepted, counting cycles until the response
// S_HOLD  | instruction captured and presented, waiting for advance
// S_FAULT | misalign or timeout seen, absorbing until reset
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_start_pc,
  input  logic [63:0] i_next_pc,
  input  logic        i_advance,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic [63:0] o_current_pc,
  output logic [31:0] o_instruction,
  output logic        o_instr_valid,
  output logic        o_misalign_fault,
  output logic        o_bus_fault,
  output logic [31:0] o_fetch_count
);

  // Counter only has to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that raises the fault instead.
  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [63:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic             r_misalign;
  logic             r_bus_fault;
  logic [31:0]      r_fetch_count;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_capture;
  logic             w_take_next;
  logic             w_set_misalign;
  logic             w_set_bus_fault;
  logic             w_to_clr;
  logic             w_to_inc;

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_capture       = 1'b0;
    w_take_next     = 1'b0;
    w_set_misalign  = 1'b0;
    w_set_bus_fault = 1'b0;
    w_to_clr        = 1'b0;
    w_to_inc        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pc[1:0] != 2'b00) begin
          w_set_misalign = 1'b1;
          w_state_nxt    = S_FAULT;
        end else begin
          w_state_nxt    = S_REQ;
        end
      end

      S_REQ: begin
        if (i_imem_req_ready) begin
          w_to_clr    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // A response in the same cycle as the last allowed one still wins.
        if (i_imem_rsp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_to_cnt == TO_LAST) begin
          w_set_bus_fault = 1'b1;
          w_state_nxt     = S_FAULT;
        end else begin
          w_to_inc = 1'b1;
        end
      end

      S_HOLD: begin
        if (i_advance) begin
          // The PC is loaded even when it is misaligned so the faulting
          // address stays visible on o_current_pc.
          w_take_next = 1'b1;
          if (i_next_pc[1:0] != 2'b00) begin
            w_set_misalign = 1'b1;
            w_state_nxt    = S_FAULT;
          end else begin
            w_state_nxt    = S_REQ;
          end
        end
      end

      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= i_start_pc;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_bus_fault   <= 1'b0;
      r_fetch_count <= 32'd0;
      r_to_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_take_next) begin
        r_pc          <= i_next_pc;
        r_instr_valid <= 1'b0;
      end

      if (w_capture) begin
        r_instr       <= i_imem_rsp_data;
        r_instr_valid <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      if (w_set_misalign) begin
        r_misalign <= 1'b1;
      end

      if (w_set_bus_fault) begin
        r_bus_fault <= 1'b1;
      end

      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: request valid is a pure state decode, everything else is a
  // register, so no input reaches an output combinationally.
  // -------------------------------------------------------------------------
  assign o_imem_req_valid = (r_state == S_REQ);
  assign o_imem_addr      = r_pc;
  assign o_current_pc     = r_pc;
  assign o_instruction    = r_instr;
  assign o_instr_valid    = r_instr_valid;
  assign o_misalign_fault = r_misalign;
  assign o_bus_fault      = r_bus_fault;
  assign o_fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] start_pc;
  logic [63:0] next_pc;
  logic        advance;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] imem_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [63:0] cur_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic        bus_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.TIMEOUT(8)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start_pc       (start_pc),
    .i_next_pc        (next_pc),
    .i_advance        (advance),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_current_pc     (cur_pc),
    .o_instruction    (instr),
    .o_instr_valid    (instr_valid),
    .o_misalign_fault (misalign),
    .o_bus_fault      (bus_fault),
    .o_fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    start_pc  = 64'h1000;
    next_pc   = 64'h0;
    advance   = 1'b0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;

    // Reset values
    step(); step();
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_addr", imem_addr, 64'h1000);
    chk("rst_pc", cur_pc, 64'h1000);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_iv", {63'd0, instr_valid}, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    chk("rst_bus", {63'd0, bus_fault}, 64'd0);
    chk("rst_count", {32'd0, fetch_count}, 64'd0);

    // First fetch: IDLE, REQ, WAIT, HOLD
    reset = 1'b0;
    step();
    chk("f1_req", {63'd0, req_valid}, 64'd1);
    chk("f1_addr", imem_addr, 64'h1000);
    step();
    chk("f1_wait_req", {63'd0, req_valid}, 64'd0);
    chk("f1_wait_iv", {63'd0, instr_valid}, 64'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h8B02_0020;
    step();
    rsp_valid = 1'b0;
    chk("f1_iv", {63'd0, instr_valid}, 64'd1);
    chk("f1_instr", {32'd0, instr}, 64'h8B02_0020);
    chk("f1_count", {32'd0, fetch_count}, 64'd1);
    step();
    chk("f1_hold_iv", {63'd0, instr_valid}, 64'd1);
    chk("f1_hold_req", {63'd0, req_valid}, 64'd0);

    // Second fetch, advance held high through WAIT
    advance = 1'b1;
    next_pc = 64'h1004;
    step();
    chk("f2_req", {63'd0, req_valid}, 64'd1);
    chk("f2_addr", imem_addr, 64'h1004);
    chk("f2_iv_clr", {63'd0, instr_valid}, 64'd0);
    step();
    next_pc   = 64'h2000;
    rsp_valid = 1'b1;
    rsp_data  = 32'h00A0_0093;
    step();
    rsp_valid = 1'b0;
    advance   = 1'b0;
    chk("f2_pc_kept", cur_pc, 64'h1004);
    chk("f2_iv", {63'd0, instr_valid}, 64'd1);
    chk("f2_instr", {32'd0, instr}, 64'h00A0_0093);
    chk("f2_count", {32'd0, fetch_count}, 64'd2);

    // Ready low 5 cycles, response in the 8th WAIT cycle (boundary)
    advance   = 1'b1;
    next_pc   = 64'h1008;
    req_ready = 1'b0;
    step();
    advance = 1'b0;
    chk("f3_req0", {63'd0, req_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("f3_req_held", {63'd0, req_valid}, 64'd1);
    end
    req_ready = 1'b1;
    step();
    chk("f3_req_done", {63'd0, req_valid}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("f3_wait_iv", {63'd0, instr_valid}, 64'd0);
      chk("f3_wait_bus", {63'd0, bus_fault}, 64'd0);
    end
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234_5678;
    step();
    rsp_valid = 1'b0;
    chk("f3_iv", {63'd0, instr_valid}, 64'd1);
    chk("f3_instr", {32'd0, instr}, 64'h1234_5678);
    chk("f3_bus", {63'd0, bus_fault}, 64'd0);
    chk("f3_count", {32'd0, fetch_count}, 64'd3);
    chk("f3_pc", cur_pc, 64'h1008);

    // Timeout: no response for 8 WAIT cycles
    advance = 1'b1;
    next_pc = 64'h100C;
    step();
    advance = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_no_fault_yet", {63'd0, bus_fault}, 64'd0);
    end
    step();
    chk("to_bus", {63'd0, bus_fault}, 64'd1);
    chk("to_req", {63'd0, req_valid}, 64'd0);
    rsp_valid = 1'b1;
    advance   = 1'b1;
    next_pc   = 64'h3000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_req", {63'd0, req_valid}, 64'd0);
    end
    rsp_valid = 1'b0;
    advance   = 1'b0;
    chk("fault_count", {32'd0, fetch_count}, 64'd3);
    chk("fault_pc", cur_pc, 64'h100C);
    chk("fault_bus_sticky", {63'd0, bus_fault}, 64'd1);
    chk("fault_iv", {63'd0, instr_valid}, 64'd0);

    // Misaligned start PC
    reset    = 1'b1;
    start_pc = 64'h2002;
    step();
    chk("r2_bus_clr", {63'd0, bus_fault}, 64'd0);
    chk("r2_count", {32'd0, fetch_count}, 64'd0);
    reset = 1'b0;
    step();
    chk("msp_fault", {63'd0, misalign}, 64'd1);
    chk("msp_req", {63'd0, req_valid}, 64'd0);
    step();
    chk("msp_req2", {63'd0, req_valid}, 64'd0);

    // Misaligned NextPC from HOLD
    reset    = 1'b1;
    start_pc = 64'h1000;
    step();
    chk("r3_misalign_clr", {63'd0, misalign}, 64'd0);
    chk("r3_pc", cur_pc, 64'h1000);
    reset = 1'b0;
    step();
    chk("r3_req", {63'd0, req_valid}, 64'd1);
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    chk("r3_iv", {63'd0, instr_valid}, 64'd1);
    advance = 1'b1;
    next_pc = 64'h1006;
    step();
    advance = 1'b0;
    chk("mna_pc", cur_pc, 64'h1006);
    chk("mna_fault", {63'd0, misalign}, 64'd1);
    chk("mna_req", {63'd0, req_valid}, 64'd0);
    chk("mna_iv", {63'd0, instr_valid}, 64'd0);
    next_pc = 64'h1010;
    advance = 1'b1;
    step();
    advance = 1'b0;
    chk("mna_pc_frozen", cur_pc, 64'h1006);
    chk("mna_req_stay", {63'd0, req_valid}, 64'd0);

    // Reset clears the fault and restarts at StartPC
    reset = 1'b1;
    step();
    chk("r4_misalign", {63'd0, misalign}, 64'd0);
    reset = 1'b0;
    step();
    chk("r4_req", {63'd0, req_valid}, 64'd1);
    chk("r4_addr", imem_addr, 64'h1000);

    // Reset during WAIT with a response in the same cycle
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'hCAFE_F00D;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_count", {32'd0, fetch_count}, 64'd0);
    chk("rw_iv", {63'd0, instr_valid}, 64'd0);
    chk("rw_instr", {32'd0, instr}, 64'd0);
    chk("rw_idle_req", {63'd0, req_valid}, 64'd0);
    step();
    chk("rw_req", {63'd0, req_valid}, 64'd1);
    chk("rw_req_rsp_ignored", {32'd0, fetch_count}, 64'd0);
    rsp_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
